axis_frame_source: RTL and testbench

- AXI4-Stream video frame transmitter: on each accepted fsync pulse, emits exactly one frame of height x width pixels with tuser on start-of-frame (SOF) and tlast on end-of-line (EOL).
- Drives the s_axis slave port of axis_scaler and other video consumers, both as a synthesizable test-pattern source in hardware and as a bench stimulus source.
- Obeys the same per-line/per-frame framing that those consumers check.

---
 rtl/axis_frame_source_pkg.sv | 20 ++
 rtl/axis_frame_source_pattern.sv | 40 ++++
 rtl/axis_frame_source.sv | 173 +++++++++++++++++
 tb/tb_axis_frame_source.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_source_pkg.sv
// Shared definitions for the AXI4-Stream frame source: default widths,
// test-pattern encodings and the frame FSM state type.
package axis_frame_source_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_DIM_WIDTH   = 12;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_COL   = 2'd1,
    PAT_ROW   = 2'd2,
    PAT_INDEX = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/axis_frame_source_pattern.sv
// Combinational test-pattern generator: maps (row, column, running index,
// pattern) to a pixel value truncated to C_PIXEL_WIDTH bits.
module axis_frame_source_pattern
  import axis_frame_source_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int C_H_WIDTH     = DEF_DIM_WIDTH,
  parameter int C_W_WIDTH     = DEF_DIM_WIDTH
) (
  input  logic [C_H_WIDTH-1:0]     i_ridx,
  input  logic [C_W_WIDTH-1:0]     i_cidx,
  input  logic [C_PIXEL_WIDTH-1:0] i_index,
  input  logic [1:0]               i_pattern,
  output logic [C_PIXEL_WIDTH-1:0] o_tdata
);

  // Scratch width wide enough for ridx*256 + cidx and for the pixel itself.
  localparam int SW_A = C_H_WIDTH + 8;
  localparam int SW_B = (SW_A > C_W_WIDTH) ? SW_A : C_W_WIDTH;
  localparam int SW   = ((SW_B > C_PIXEL_WIDTH) ? SW_B : C_PIXEL_WIDTH) + 1;

  logic [SW-1:0] w_ramp;
  logic [SW-1:0] w_col;
  logic [SW-1:0] w_row;

  always_comb begin
    w_ramp  = (SW'(i_ridx) << 8) + SW'(i_cidx);
    w_col   = SW'(i_cidx);
    w_row   = SW'(i_ridx);
    o_tdata = '0;
    case (pattern_e'(i_pattern))
      PAT_RAMP:  o_tdata = w_ramp[C_PIXEL_WIDTH-1:0];
      PAT_COL:   o_tdata = w_col[C_PIXEL_WIDTH-1:0];
      PAT_ROW:   o_tdata = w_row[C_PIXEL_WIDTH-1:0];
      PAT_INDEX: o_tdata = i_index;
      default:   o_tdata = '0;
    endcase
  end

endmodule

// File: rtl/axis_frame_source.sv
// AXI4-Stream video frame source: one height x width frame per accepted fsync,
// tuser on the first pixel, tlast on the last column of every row.
module axis_frame_source
  import axis_frame_source_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int C_H_WIDTH     = DEF_DIM_WIDTH,
  parameter int C_W_WIDTH     = DEF_DIM_WIDTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     fsync,
  input  logic [C_H_WIDTH-1:0]     height,
  input  logic [C_W_WIDTH-1:0]     width,
  input  logic [1:0]               pattern,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  fsm_state_e               r_state;
  logic [C_H_WIDTH-1:0]     r_h;
  logic [C_H_WIDTH-1:0]     r_ridx;
  logic [C_W_WIDTH-1:0]     r_w;
  logic [C_W_WIDTH-1:0]     r_cidx;
  logic [C_PIXEL_WIDTH-1:0] r_index;
  logic [1:0]               r_pat;
  logic [C_PIXEL_WIDTH-1:0] r_tdata;
  logic                     r_tuser;
  logic                     r_tlast;
  logic                     r_tvalid;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_overrun;

  logic                     w_accept;
  logic                     w_xfer;
  logic                     w_last_col;
  logic                     w_last_row;
  logic [C_H_WIDTH-1:0]     w_nxt_ridx;
  logic [C_W_WIDTH-1:0]     w_nxt_cidx;
  logic [C_W_WIDTH-1:0]     w_nxt_w;
  logic [C_PIXEL_WIDTH-1:0] w_nxt_index;
  logic [1:0]               w_nxt_pat;
  logic                     w_nxt_tuser;
  logic                     w_nxt_tlast;
  logic [C_PIXEL_WIDTH-1:0] w_pix;

  // Next-pixel position is computed ahead so tdata/tuser/tlast can be
  // registered on the same edge the counters advance.
  always_comb begin
    w_accept   = (r_state == ST_IDLE) && fsync && (height != '0) && (width != '0);
    w_xfer     = (r_state == ST_STREAM) && r_tvalid && m_axis_tready;
    w_last_col = (r_cidx == r_w - 1'b1);
    w_last_row = (r_ridx == r_h - 1'b1);
    w_nxt_ridx  = r_ridx;
    w_nxt_cidx  = r_cidx;
    w_nxt_w     = r_w;
    w_nxt_index = r_index;
    w_nxt_pat   = r_pat;
    if (w_accept) begin
      w_nxt_ridx  = '0;
      w_nxt_cidx  = '0;
      w_nxt_w     = width;
      w_nxt_index = '0;
      w_nxt_pat   = pattern;
    end else begin
      w_nxt_index = r_index + 1'b1;
      if (w_last_col) begin
        w_nxt_cidx = '0;
        w_nxt_ridx = r_ridx + 1'b1;
      end else begin
        w_nxt_cidx = r_cidx + 1'b1;
      end
    end
    w_nxt_tuser = (w_nxt_ridx == '0) && (w_nxt_cidx == '0);
    w_nxt_tlast = (w_nxt_cidx == w_nxt_w - 1'b1);
  end

  axis_frame_source_pattern #(
    .C_PIXEL_WIDTH(C_PIXEL_WIDTH),
    .C_H_WIDTH    (C_H_WIDTH),
    .C_W_WIDTH    (C_W_WIDTH)
  ) u_pattern (
    .i_ridx   (w_nxt_ridx),
    .i_cidx   (w_nxt_cidx),
    .i_index  (w_nxt_index),
    .i_pattern(w_nxt_pat),
    .o_tdata  (w_pix)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_h       <= '0;
      r_w       <= '0;
      r_ridx    <= '0;
      r_cidx    <= '0;
      r_index   <= '0;
      r_pat     <= '0;
      r_tdata   <= '0;
      r_tuser   <= 1'b0;
      r_tlast   <= 1'b0;
      r_tvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_STREAM;
            r_h      <= height;
            r_w      <= width;
            r_pat    <= pattern;
            r_ridx   <= '0;
            r_cidx   <= '0;
            r_index  <= '0;
            r_tdata  <= w_pix;
            r_tuser  <= 1'b1;
            r_tlast  <= w_nxt_tlast;
            r_tvalid <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ST_STREAM: begin
          // Requests during a frame, including on its final handshake, are dropped.
          if (fsync) begin
            r_overrun <= 1'b1;
          end
          if (w_xfer) begin
            if (w_last_col && w_last_row) begin
              r_state  <= ST_IDLE;
              r_ridx   <= '0;
              r_cidx   <= '0;
              r_index  <= '0;
              r_tdata  <= '0;
              r_tuser  <= 1'b0;
              r_tlast  <= 1'b0;
              r_tvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_ridx  <= w_nxt_ridx;
              r_cidx  <= w_nxt_cidx;
              r_index <= w_nxt_index;
              r_tdata <= w_pix;
              r_tuser <= w_nxt_tuser;
              r_tlast <= w_nxt_tlast;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;
  assign busy          = r_busy;
  assign frame_done    = r_done;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: directed and randomized frames
// compared against an arithmetic model of the frame's pixel sequence.
module tb_axis_frame_source;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fsync;
  logic [11:0] height;
  logic [11:0] width;
  logic [1:0]  pattern;
  logic [7:0]  tdata;
  logic        tuser;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  axis_frame_source #(
    .C_PIXEL_WIDTH(8),
    .C_H_WIDTH    (12),
    .C_W_WIDTH    (12)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .fsync        (fsync),
    .height       (height),
    .width        (width),
    .pattern      (pattern),
    .m_axis_tdata (tdata),
    .m_axis_tuser (tuser),
    .m_axis_tlast (tlast),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel n of a frame sits at row n/w, column n%w; pattern 3 is simply n.
  function automatic logic [7:0] exp_pix(input int n, input int w, input int pat);
    int r, c, v;
    r = n / w;
    c = n % w;
    case (pat)
      0:       v = r * 256 + c;
      1:       v = c;
      2:       v = r;
      default: v = n;
    endcase
    return v[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int h, input int w, input int pat, input int rdy_pct,
                           input int ovr_at, input int abort_at);
    int total, n, cyc;
    bit ovr_exp;
    total = (abort_at >= 0) ? abort_at : h * w;
    fsync = 1'b1; height = 12'(h); width = 12'(w); pattern = 2'(pat); tready = 1'b0;
    step();
    fsync = 1'b0;
    height = 12'($urandom); width = 12'($urandom); pattern = 2'($urandom);
    n = 0; cyc = 0; ovr_exp = 1'b0;
    while (n < total && cyc < 40 * h * w + 100) begin
      chk("tvalid", tvalid, 1);
      chk("busy", busy, 1);
      chk("overrun", overrun, ovr_exp);
      chk("frame_done_mid", frame_done, 0);
      chk("tdata", tdata, exp_pix(n, w, pat));
      chk("tuser", tuser, n == 0);
      chk("tlast", tlast, (n % w) == w - 1);
      tready  = int'($urandom_range(99)) < rdy_pct;
      ovr_exp = (n == ovr_at);
      fsync   = ovr_exp;
      if (tready) n++;
      cyc++;
      step();
      fsync = 1'b0;
    end
    if (n < total) chk("timeout", n, total);
    tready = 1'b0;
    if (abort_at >= 0) begin
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("abort_tvalid", tvalid, 0);
      chk("abort_tdata", tdata, 0);
      chk("abort_tuser", tuser, 0);
      chk("abort_tlast", tlast, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", frame_done, 0);
      chk("abort_overrun", overrun, 0);
      repeat (3) begin
        step();
        chk("abort_done_later", frame_done, 0);
        chk("abort_tvalid_later", tvalid, 0);
      end
    end else begin
      chk("end_tvalid", tvalid, 0);
      chk("end_busy", busy, 0);
      chk("frame_done", frame_done, 1);
      chk("end_overrun", overrun, ovr_exp);
      repeat (2) begin
        step();
        chk("done_pulse", frame_done, 0);
        chk("overrun_pulse", overrun, 0);
        chk("idle_tvalid", tvalid, 0);
        chk("idle_busy", busy, 0);
      end
    end
  endtask

  task automatic zero_dim(input int h, input int w);
    fsync = 1'b1; height = 12'(h); width = 12'(w); pattern = 2'd0; tready = 1'b1;
    step();
    fsync = 1'b0;
    repeat (3) begin
      chk("zero_tvalid", tvalid, 0);
      chk("zero_busy", busy, 0);
      chk("zero_done", frame_done, 0);
      chk("zero_overrun", overrun, 0);
      step();
    end
    tready = 1'b0;
  endtask

  initial begin
    int h, w;
    resetn = 1'b0; fsync = 1'b0; height = '0; width = '0; pattern = '0; tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    resetn = 1'b1;
    step();

    run_frame(2, 3, 1, 100, -1, -1);
    run_frame(4, 5, 0, 50, -1, -1);
    run_frame(5, 4, 2, 70, 7, -1);
    run_frame(3, 3, 0, 100, 8, -1);
    zero_dim(3, 0);
    zero_dim(0, 4);
    run_frame(3, 1, 3, 60, -1, -1);
    run_frame(4, 4, 3, 100, -1, 7);
    run_frame(4, 4, 3, 100, -1, -1);
    run_frame(20, 17, 3, 80, -1, -1);
    run_frame(2, 300, 0, 90, -1, -1);
    for (int k = 0; k < 6; k++) begin
      h = int'($urandom_range(1, 6));
      w = int'($urandom_range(1, 9));
      run_frame(h, w, int'($urandom_range(0, 3)), int'($urandom_range(30, 100)),
                int'($urandom_range(0, h * w - 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
